butterfly_inv: RTL
==================

BUTTERFLY_INV -- requirements
Module: butterfly_inv

Interface
REQ-001 SHALL have parameter N, default 16: transform length; twiddle index range 0..N/2-1.
REQ-002 SHALL have parameter W, default 16: twiddle word width (signed Q2.(W-2); 1.0 = 2^(W-2)).
REQ-003 SHALL derive IW = W + N/2 (input component width), OW = IW + 2 (output component width), KW = $clog2(N/2).
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have ports a_re, a_im, b_re, b_im, input, IW each, signed: upper and lower input pair.
REQ-007 SHALL have port k, input, KW: twiddle index.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_last (input, 1, frame tag).
REQ-009 SHALL have ports y0_re, y0_im, y1_re, y1_im, output, OW each, signed.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_last (output, 1).

Function
REQ-011 SHALL compute the radix-2 decimation-in-frequency inverse butterfly: Y0 = A + B; Y1 = (A - B) * conj(W_N^k).
REQ-012 SHALL use c = round(cos(2*pi*k/N)*2^(W-2)) and s = round(sin(2*pi*k/N)*2^(W-2)) from an internal ROM built at elaboration; no external LUT.
REQ-013 SHALL form D = A - B at IW+1 bits; y1_re = D_re*c - D_im*s; y1_im = D_re*s + D_im*c, using full-precision products.
REQ-014 SHALL round y1 by adding 2^(W-3) and then arithmetically shifting right by W-2 (round half up); the result SHALL be truncated to OW bits.
REQ-015 SHALL sign-extend y0 to OW bits.
REQ-016 SHALL be a 3-stage pipeline:
- S1 registers A+B, A-B and the (c, s) lookup.
- S2 registers the four products.
- S3 registers the combined and rounded results.
REQ-017 SHALL have a latency of exactly 3 accepted-and-advancing cycles from the in_valid&in_ready edge to out_valid.
REQ-018 SHALL define the advance enable as en = !out_valid | out_ready; in_ready = en; all stages SHALL hold when en = 0.
REQ-019 SHALL accept one input per cycle when in_valid & in_ready, giving a throughput of 1 per cycle with out_ready held high.
REQ-020 SHALL propagate bubbles: a stage valid bit SHALL load the previous stage's valid bit when en = 1.
REQ-021 SHALL carry in_last alongside the data and present it as out_last, aligned with its own result.
REQ-022 SHALL hold y*, out_valid and out_last stable while out_valid & !out_ready.
REQ-023 SHALL treat k >= N/2 as k mod (N/2).

Reset
REQ-024 SHALL, while rst_n = 0, asynchronously clear all stage valid bits, out_valid, out_last and y0/y1 to 0.
REQ-025 SHALL drive in_ready = 1 during and after reset, per REQ-018.
REQ-026 SHALL discard all in-flight data when reset asserts mid-operation; no output SHALL appear after release without new input.

Configuration
REQ-027 SHALL, when macro BUTTERFLY_INV_SCALE_EN is defined, scale both outputs by 1/2: add 1, then arithmetic shift right 1, applied in S3 after the REQ-014 rounding.
REQ-028 SHALL, when BUTTERFLY_INV_SCALE_EN is undefined, produce unscaled outputs with widths and latency unchanged.

Verification
REQ-029 SHALL cover (N=16, W=16, unscaled): A=(100,50), B=(20,-10), k=0 -> y0=(120,40), y1=(80,60), out_valid exactly 3 cycles after acceptance.
REQ-030 SHALL cover: same A, B with k=4 -> y1=(-60,80); y0=(120,40).
REQ-031 SHALL cover (BUTTERFLY_INV_SCALE_EN defined): k=0 case -> y0=(60,20), y1=(40,30).
REQ-032 SHALL cover backpressure: 8 back-to-back inputs with out_ready low for cycles 4-6 -> in_ready low for those cycles, no loss or duplication, outputs in order, out_last on input 8 only.
REQ-033 SHALL cover reset: assert rst_n = 0 with 2 items in flight -> out_valid = 0 immediately, outputs 0, nothing emitted after release.

Source files
------------

// File: rtl/butterfly_inv.sv
`default_nettype none
// ============================================================================
// butterfly_inv : 3-stage radix-2 DIF inverse butterfly, Y0 = A+B, Y1 = (A-B)*conj(W_N^k)
// Optional BUTTERFLY_INV_SCALE_EN halves both outputs.        Rev 1.0
// ============================================================================
module butterfly_inv #(
    parameter int N = 16,
    parameter int W = 16,
    localparam int IW = W + N / 2,
    localparam int OW = IW + 2,
    localparam int KW = $clog2(N / 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [IW-1:0] a_re,
    input  logic signed [IW-1:0] a_im,
    input  logic signed [IW-1:0] b_re,
    input  logic signed [IW-1:0] b_im,
    input  logic        [KW-1:0] k,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    output logic signed [OW-1:0] y0_re,
    output logic signed [OW-1:0] y0_im,
    output logic signed [OW-1:0] y1_re,
    output logic signed [OW-1:0] y1_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);
    localparam int c_dw = IW + 1;
    localparam int c_pw = c_dw + W;
    localparam int c_cw = c_pw + 1;
    localparam int c_fb = 28;
    localparam longint c_pi_q = 64'sd843314857;
    localparam logic signed [c_cw-1:0] c_rnd = c_cw'(1) <<< (W - 3);

    // Q(c_fb) Taylor series so the ROM is built from integer constant math only.
    function automatic longint trig_q(input int idx, input logic want_sin);
        longint x, term, acc;
        int     d, sh;
        x    = (2 * c_pi_q * idx) / N;
        term = want_sin ? x : (64'sd1 <<< c_fb);
        acc  = term;
        for (int n = 1; n < 16; n++) begin
            d    = want_sin ? (2 * n) * (2 * n + 1) : (2 * n - 1) * (2 * n);
            term = -((((term * x) >>> c_fb) * x) >>> c_fb) / d;
            acc  = acc + term;
        end
        sh = c_fb - (W - 2);
        return (acc + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    logic signed [W-1:0] w_cos_rom [N/2];
    logic signed [W-1:0] w_sin_rom [N/2];

    for (genvar i = 0; i < N / 2; i++) begin : g_rom
        localparam logic signed [W-1:0] c_cos = W'(trig_q(i, 1'b0));
        localparam logic signed [W-1:0] c_sin = W'(trig_q(i, 1'b1));
        assign w_cos_rom[i] = c_cos;
        assign w_sin_rom[i] = c_sin;
    end

    logic                   w_en;
    logic                   r_s1_valid, r_s2_valid, r_s3_valid;
    logic                   r_s1_last, r_s2_last, r_s3_last;
    logic signed [c_dw-1:0] r_s1_sum_re, r_s1_sum_im, r_s1_dif_re, r_s1_dif_im;
    logic signed [W-1:0]    r_s1_c, r_s1_s;
    logic signed [c_dw-1:0] r_s2_sum_re, r_s2_sum_im;
    logic signed [c_pw-1:0] r_s2_rc, r_s2_is, r_s2_rs, r_s2_ic;
    logic signed [c_cw-1:0] w_y1_re_full, w_y1_im_full, w_y1_re_rnd, w_y1_im_rnd;
    logic signed [OW-1:0]   w_y0_re, w_y0_im, w_y1_re, w_y1_im;
    logic signed [OW-1:0]   r_y0_re, r_y0_im, r_y1_re, r_y1_im;

    assign w_en     = !r_s3_valid || out_ready;
    assign in_ready = w_en;

    assign w_y1_re_full = c_cw'(r_s2_rc) - c_cw'(r_s2_is);
    assign w_y1_im_full = c_cw'(r_s2_rs) + c_cw'(r_s2_ic);
    assign w_y1_re_rnd  = (w_y1_re_full + c_rnd) >>> (W - 2);
    assign w_y1_im_rnd  = (w_y1_im_full + c_rnd) >>> (W - 2);

`ifdef BUTTERFLY_INV_SCALE_EN
    assign w_y0_re = (OW'(r_s2_sum_re) + OW'(1)) >>> 1;
    assign w_y0_im = (OW'(r_s2_sum_im) + OW'(1)) >>> 1;
    assign w_y1_re = OW'((w_y1_re_rnd + c_cw'(1)) >>> 1);
    assign w_y1_im = OW'((w_y1_im_rnd + c_cw'(1)) >>> 1);
`else
    assign w_y0_re = OW'(r_s2_sum_re);
    assign w_y0_im = OW'(r_s2_sum_im);
    assign w_y1_re = OW'(w_y1_re_rnd);
    assign w_y1_im = OW'(w_y1_im_rnd);
`endif

    // Every stage advances on the same enable, so a stalled output freezes the whole pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s3_last   <= 1'b0;
            r_s1_sum_re <= '0;
            r_s1_sum_im <= '0;
            r_s1_dif_re <= '0;
            r_s1_dif_im <= '0;
            r_s1_c      <= '0;
            r_s1_s      <= '0;
            r_s2_sum_re <= '0;
            r_s2_sum_im <= '0;
            r_s2_rc     <= '0;
            r_s2_is     <= '0;
            r_s2_rs     <= '0;
            r_s2_ic     <= '0;
            r_y0_re     <= '0;
            r_y0_im     <= '0;
            r_y1_re     <= '0;
            r_y1_im     <= '0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s1_last   <= in_last;
            r_s1_sum_re <= c_dw'(a_re) + c_dw'(b_re);
            r_s1_sum_im <= c_dw'(a_im) + c_dw'(b_im);
            r_s1_dif_re <= c_dw'(a_re) - c_dw'(b_re);
            r_s1_dif_im <= c_dw'(a_im) - c_dw'(b_im);
            r_s1_c      <= w_cos_rom[k];
            r_s1_s      <= w_sin_rom[k];

            r_s2_valid  <= r_s1_valid;
            r_s2_last   <= r_s1_last;
            r_s2_sum_re <= r_s1_sum_re;
            r_s2_sum_im <= r_s1_sum_im;
            r_s2_rc     <= c_pw'(r_s1_dif_re) * c_pw'(r_s1_c);
            r_s2_is     <= c_pw'(r_s1_dif_im) * c_pw'(r_s1_s);
            r_s2_rs     <= c_pw'(r_s1_dif_re) * c_pw'(r_s1_s);
            r_s2_ic     <= c_pw'(r_s1_dif_im) * c_pw'(r_s1_c);

            r_s3_valid  <= r_s2_valid;
            r_s3_last   <= r_s2_last;
            r_y0_re     <= w_y0_re;
            r_y0_im     <= w_y0_im;
            r_y1_re     <= w_y1_re;
            r_y1_im     <= w_y1_im;
        end
    end

    assign y0_re     = r_y0_re;
    assign y0_im     = r_y0_im;
    assign y1_re     = r_y1_re;
    assign y1_im     = r_y1_im;
    assign out_valid = r_s3_valid;
    assign out_last  = r_s3_last;

endmodule
`default_nettype wire
